// File: rtl/sys_defs.sv
`default_nettype none
// ============================================================================
// sys_defs : shared widths and load-arbiter slot state encoding.
// Revision : 1.0
// ============================================================================
`ifndef NUM_LD
`define NUM_LD 2
`endif
`ifndef XLEN
`define XLEN 32
`endif

package sys_defs;

    typedef enum logic [1:0] {
        LD_IDLE   = 2'd0,
        LD_QUEUED = 2'd1,
        LD_MISS   = 2'd2
    } LD_ARB_STATE;

endpackage
`default_nettype wire

// File: rtl/rr_arbiter.sv
`default_nettype none
// ============================================================================
// rr_arbiter : round-robin pick of one request, searching upward from ptr_i.
// Revision   : 1.0
// ============================================================================
module rr_arbiter #(
    parameter int N     = 2,
    parameter int PTR_W = 1
) (
    input  logic [N-1:0]     req_i,
    input  logic [PTR_W-1:0] ptr_i,
    output logic [N-1:0]     gnt_o,
    output logic [PTR_W-1:0] gnt_idx_o,
    output logic             valid_o
);

    int best_dist;
    int cand_dist;

    // Winner is the requester with the smallest rotated distance from ptr_i.
    always_comb begin
        best_dist = N;
        cand_dist = 0;
        gnt_idx_o = '0;
        gnt_o     = '0;
        for (int j = 0; j < N; j++) begin
            cand_dist = (j + N - int'(ptr_i)) % N;
            if (req_i[j] && (cand_dist < best_dist)) begin
                best_dist = cand_dist;
                gnt_idx_o = PTR_W'(j);
            end
        end
        valid_o = (best_dist < N);
        for (int j = 0; j < N; j++) begin
            gnt_o[j] = valid_o && (int'(gnt_idx_o) == j);
        end
    end

endmodule
`default_nettype wire

// File: rtl/load_cache_arbiter.sv
`default_nettype none
// ============================================================================
// load_cache_arbiter : shares one D-cache read port among NUM_LD load FUs.
// Revision           : 1.0
// ============================================================================
module load_cache_arbiter
    import sys_defs::*;
#(
    parameter int NUM_LD = `NUM_LD,
    parameter int XLEN   = `XLEN
) (
    input  logic                         clock,
    input  logic                         reset,
    input  logic [NUM_LD-1:0]            ld_read_EN,
    input  logic [NUM_LD-1:0][XLEN-1:0]  ld_addr,
    output logic [NUM_LD-1:0]            ld_is_hit,
    output logic [NUM_LD-1:0][XLEN-1:0]  ld_data,
    output logic [NUM_LD-1:0]            ld_broadcast_en,
    output logic [NUM_LD-1:0][XLEN-1:0]  ld_broadcast_data,
    input  logic                         dc_stall,
    output logic                         dc_read_EN,
    output logic [XLEN-1:0]              dc_addr,
    input  logic                         dc_is_hit,
    input  logic [XLEN-1:0]              dc_data,
    input  logic                         dc_bc_en,
    input  logic [XLEN-1:0]              dc_bc_addr,
    input  logic [XLEN-1:0]              dc_bc_data,
    output logic                         err_overflow
);

    localparam int PTR_W = (NUM_LD > 1) ? $clog2(NUM_LD) : 1;

    LD_ARB_STATE                  state_q [NUM_LD];
    LD_ARB_STATE                  state_d [NUM_LD];
    logic [NUM_LD-1:0][XLEN-1:0]  addr_q, addr_d;
    logic [PTR_W-1:0]             rr_ptr_q, rr_ptr_d;
    logic                         err_q, err_d;
    logic [NUM_LD-1:0]            hit_q, hit_d;
    logic [NUM_LD-1:0][XLEN-1:0]  hdata_q, hdata_d;
    logic [NUM_LD-1:0]            bcen_q, bcen_d;
    logic [NUM_LD-1:0][XLEN-1:0]  bcdata_q, bcdata_d;

    logic [NUM_LD-1:0]            req_w;
    logic [NUM_LD-1:0]            gnt_w;
    logic [PTR_W-1:0]             gnt_idx_w;
    logic                         gnt_valid_w;

    always_comb begin
        for (int i = 0; i < NUM_LD; i++) begin
            req_w[i] = (state_q[i] == LD_QUEUED) && !dc_stall;
        end
    end

    rr_arbiter #(
        .N     (NUM_LD),
        .PTR_W (PTR_W)
    ) u_rr_arbiter (
        .req_i     (req_w),
        .ptr_i     (rr_ptr_q),
        .gnt_o     (gnt_w),
        .gnt_idx_o (gnt_idx_w),
        .valid_o   (gnt_valid_w)
    );

    always_comb begin
        dc_read_EN = gnt_valid_w;
        dc_addr    = '0;
        for (int i = 0; i < NUM_LD; i++) begin
            if (gnt_w[i]) dc_addr = addr_q[i];
        end
    end

    always_comb begin
        state_d  = state_q;
        addr_d   = addr_q;
        rr_ptr_d = rr_ptr_q;
        err_d    = err_q;
        hit_d    = '0;
        hdata_d  = '0;
        bcen_d   = '0;
        bcdata_d = '0;

        if (gnt_valid_w) begin
            rr_ptr_d = (int'(gnt_idx_w) == NUM_LD - 1) ? '0 : gnt_idx_w + PTR_W'(1);
        end

        for (int i = 0; i < NUM_LD; i++) begin
            if (ld_read_EN[i] && (state_q[i] != LD_IDLE)) err_d = 1'b1;
            case (state_q[i])
                LD_IDLE: begin
                    if (ld_read_EN[i]) begin
                        state_d[i] = LD_QUEUED;
                        addr_d[i]  = ld_addr[i];
                    end
                end
                LD_QUEUED: begin
                    if (gnt_w[i]) begin
                        if (dc_is_hit) begin
                            hit_d[i]   = 1'b1;
                            hdata_d[i] = dc_data;
                            state_d[i] = LD_IDLE;
                        // A fill landing on the very address being looked up counts as a hit.
                        end else if (dc_bc_en && (dc_bc_addr == addr_q[i])) begin
                            hit_d[i]   = 1'b1;
                            hdata_d[i] = dc_bc_data;
                            state_d[i] = LD_IDLE;
                        end else begin
                            state_d[i] = LD_MISS;
                        end
                    end
                end
                LD_MISS: begin
                    if (dc_bc_en && (dc_bc_addr[XLEN-1:2] == addr_q[i][XLEN-1:2])) begin
                        bcen_d[i]   = 1'b1;
                        bcdata_d[i] = dc_bc_data;
                        state_d[i]  = LD_IDLE;
                    end
                end
                default: state_d[i] = LD_IDLE;
            endcase
        end
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            for (int i = 0; i < NUM_LD; i++) begin
                state_q[i] <= LD_IDLE;
            end
            addr_q   <= '0;
            rr_ptr_q <= '0;
            err_q    <= 1'b0;
            hit_q    <= '0;
            hdata_q  <= '0;
            bcen_q   <= '0;
            bcdata_q <= '0;
        end else begin
            state_q  <= state_d;
            addr_q   <= addr_d;
            rr_ptr_q <= rr_ptr_d;
            err_q    <= err_d;
            hit_q    <= hit_d;
            hdata_q  <= hdata_d;
            bcen_q   <= bcen_d;
            bcdata_q <= bcdata_d;
        end
    end

    assign ld_is_hit         = hit_q;
    assign ld_data           = hdata_q;
    assign ld_broadcast_en   = bcen_q;
    assign ld_broadcast_data = bcdata_q;
    assign err_overflow      = err_q;

endmodule
`default_nettype wire

// File: tb/tb_load_cache_arbiter.sv
`default_nettype none
// ============================================================================
// tb_load_cache_arbiter : per-cycle vector table plus reset corner sequences.
// Revision              : 1.0
// ============================================================================
module tb_load_cache_arbiter;

    logic              clock = 1'b0;
    logic              reset;
    logic [1:0]        ld_read_EN;
    logic [1:0][31:0]  ld_addr;
    logic [1:0]        ld_is_hit;
    logic [1:0][31:0]  ld_data;
    logic [1:0]        ld_broadcast_en;
    logic [1:0][31:0]  ld_broadcast_data;
    logic              dc_stall;
    logic              dc_read_EN;
    logic [31:0]       dc_addr;
    logic              dc_is_hit;
    logic [31:0]       dc_data;
    logic              dc_bc_en;
    logic [31:0]       dc_bc_addr;
    logic [31:0]       dc_bc_data;
    logic              err_overflow;

    int checks = 0;
    int errors = 0;

    always #5 clock = ~clock;

    load_cache_arbiter #(.NUM_LD(2), .XLEN(32)) dut (
        .clock             (clock),
        .reset             (reset),
        .ld_read_EN        (ld_read_EN),
        .ld_addr           (ld_addr),
        .ld_is_hit         (ld_is_hit),
        .ld_data           (ld_data),
        .ld_broadcast_en   (ld_broadcast_en),
        .ld_broadcast_data (ld_broadcast_data),
        .dc_stall          (dc_stall),
        .dc_read_EN        (dc_read_EN),
        .dc_addr           (dc_addr),
        .dc_is_hit         (dc_is_hit),
        .dc_data           (dc_data),
        .dc_bc_en          (dc_bc_en),
        .dc_bc_addr        (dc_bc_addr),
        .dc_bc_data        (dc_bc_data),
        .err_overflow      (err_overflow)
    );

    typedef struct {
        logic [1:0]  rd;
        logic [31:0] a0, a1;
        logic        stall, hit;
        logic [31:0] dd;
        logic        bce;
        logic [31:0] bca, bcd;
        logic        e_rd;
        logic [31:0] e_addr;
        logic [1:0]  e_hit;
        logic [31:0] e_d0, e_d1;
        logic [1:0]  e_bc;
        logic [31:0] e_b0, e_b1;
        logic        e_err;
    } vec_t;

    vec_t vecs[$];

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    task automatic idle_inputs();
        ld_read_EN = '0;
        ld_addr    = '0;
        dc_stall   = 1'b0;
        dc_is_hit  = 1'b0;
        dc_data    = '0;
        dc_bc_en   = 1'b0;
        dc_bc_addr = '0;
        dc_bc_data = '0;
    endtask

    task automatic chk_all_zero(input string tag);
        chk({tag, " dc_read_EN"}, 64'(dc_read_EN), 64'd0);
        chk({tag, " dc_addr"}, 64'(dc_addr), 64'd0);
        chk({tag, " ld_is_hit"}, 64'(ld_is_hit), 64'd0);
        chk({tag, " ld_data"}, 64'(ld_data), 64'd0);
        chk({tag, " ld_broadcast_en"}, 64'(ld_broadcast_en), 64'd0);
        chk({tag, " ld_broadcast_data"}, 64'(ld_broadcast_data), 64'd0);
        chk({tag, " err_overflow"}, 64'(err_overflow), 64'd0);
    endtask

    initial begin
        // rd, a0, a1, stall, hit, dd, bce, bca, bcd | e_rd, e_addr, e_hit, e_d0, e_d1, e_bc, e_b0, e_b1, e_err
        // Contention from reset: grant 0 then 1
        vecs.push_back('{2'b11, 32'h100, 32'h200, 0, 1, 32'hAAAA0001, 0, 0, 0,  0, 32'h0,   2'b00, 0, 0, 2'b00, 0, 0, 0});
        vecs.push_back('{2'b00, 0, 0,             0, 1, 32'hAAAA0001, 0, 0, 0,  1, 32'h100, 2'b00, 0, 0, 2'b00, 0, 0, 0});
        vecs.push_back('{2'b00, 0, 0,             0, 1, 32'hBBBB0002, 0, 0, 0,  1, 32'h200, 2'b01, 32'hAAAA0001, 0, 2'b00, 0, 0, 0});
        vecs.push_back('{2'b00, 0, 0,             0, 0, 0,            0, 0, 0,  0, 32'h0,   2'b10, 0, 32'hBBBB0002, 2'b00, 0, 0, 0});
        // Pointer back at 0: FU0 wins again
        vecs.push_back('{2'b11, 32'h110, 32'h210, 0, 1, 32'h11110000, 0, 0, 0,  0, 32'h0,   2'b00, 0, 0, 2'b00, 0, 0, 0});
        vecs.push_back('{2'b00, 0, 0,             0, 1, 32'h11110000, 0, 0, 0,  1, 32'h110, 2'b00, 0, 0, 2'b00, 0, 0, 0});
        vecs.push_back('{2'b00, 0, 0,             0, 1, 32'h22220000, 0, 0, 0,  1, 32'h210, 2'b01, 32'h11110000, 0, 2'b00, 0, 0, 0});
        vecs.push_back('{2'b00, 0, 0,             0, 0, 0,            0, 0, 0,  0, 32'h0,   2'b10, 0, 32'h22220000, 2'b00, 0, 0, 0});
        // Single hit
        vecs.push_back('{2'b01, 32'h100, 0,       0, 1, 32'hDEADBEEF, 0, 0, 0,  0, 32'h0,   2'b00, 0, 0, 2'b00, 0, 0, 0});
        vecs.push_back('{2'b00, 0, 0,             0, 1, 32'hDEADBEEF, 0, 0, 0,  1, 32'h100, 2'b00, 0, 0, 2'b00, 0, 0, 0});
        vecs.push_back('{2'b00, 0, 0,             0, 0, 0,            0, 0, 0,  0, 32'h0,   2'b01, 32'hDEADBEEF, 0, 2'b00, 0, 0, 0});
        // FU1 miss, FU0 hit meanwhile, broadcast 5 cycles later
        vecs.push_back('{2'b10, 0, 32'h204,       0, 0, 0,            0, 0, 0,  0, 32'h0,   2'b00, 0, 0, 2'b00, 0, 0, 0});
        vecs.push_back('{2'b01, 32'h140, 0,       0, 0, 0,            0, 0, 0,  1, 32'h204, 2'b00, 0, 0, 2'b00, 0, 0, 0});
        vecs.push_back('{2'b00, 0, 0,             0, 1, 32'hCAFE0001, 0, 0, 0,  1, 32'h140, 2'b00, 0, 0, 2'b00, 0, 0, 0});
        vecs.push_back('{2'b00, 0, 0,             0, 0, 0,            0, 0, 0,  0, 32'h0,   2'b01, 32'hCAFE0001, 0, 2'b00, 0, 0, 0});
        vecs.push_back('{2'b00, 0, 0,             0, 0, 0,            0, 0, 0,  0, 32'h0,   2'b00, 0, 0, 2'b00, 0, 0, 0});
        vecs.push_back('{2'b00, 0, 0,             0, 0, 0,            0, 0, 0,  0, 32'h0,   2'b00, 0, 0, 2'b00, 0, 0, 0});
        vecs.push_back('{2'b00, 0, 0,             0, 0, 0,            1, 32'h204, 32'h12345678, 0, 32'h0, 2'b00, 0, 0, 2'b00, 0, 0, 0});
        vecs.push_back('{2'b00, 0, 0,             0, 0, 0,            0, 0, 0,  0, 32'h0,   2'b00, 0, 0, 2'b10, 0, 32'h12345678, 0});
        // Shared fill: both miss on 0x300, pointer at 1 so FU1 first
        vecs.push_back('{2'b11, 32'h300, 32'h300, 0, 0, 0,            0, 0, 0,  0, 32'h0,   2'b00, 0, 0, 2'b00, 0, 0, 0});
        vecs.push_back('{2'b00, 0, 0,             0, 0, 0,            0, 0, 0,  1, 32'h300, 2'b00, 0, 0, 2'b00, 0, 0, 0});
        vecs.push_back('{2'b00, 0, 0,             0, 0, 0,            0, 0, 0,  1, 32'h300, 2'b00, 0, 0, 2'b00, 0, 0, 0});
        vecs.push_back('{2'b00, 0, 0,             0, 0, 0,            1, 32'h300, 32'h55AA55AA, 0, 32'h0, 2'b00, 0, 0, 2'b00, 0, 0, 0});
        vecs.push_back('{2'b00, 0, 0,             0, 0, 0,            0, 0, 0,  0, 32'h0,   2'b00, 0, 0, 2'b11, 32'h55AA55AA, 32'h55AA55AA, 0});
        // Granted miss with same-cycle fill of that address -> hit pulse
        vecs.push_back('{2'b01, 32'h400, 0,       0, 0, 0,            0, 0, 0,  0, 32'h0,   2'b00, 0, 0, 2'b00, 0, 0, 0});
        vecs.push_back('{2'b00, 0, 0,             0, 0, 0,            1, 32'h400, 32'h0BADF00D, 1, 32'h400, 2'b00, 0, 0, 2'b00, 0, 0, 0});
        vecs.push_back('{2'b00, 0, 0,             0, 0, 0,            0, 0, 0,  0, 32'h0,   2'b01, 32'h0BADF00D, 0, 2'b00, 0, 0, 0});
        // Miss release ignores byte-offset bits; unrelated fill does nothing
        vecs.push_back('{2'b10, 0, 32'h500,       0, 0, 0,            0, 0, 0,  0, 32'h0,   2'b00, 0, 0, 2'b00, 0, 0, 0});
        vecs.push_back('{2'b00, 0, 0,             0, 0, 0,            0, 0, 0,  1, 32'h500, 2'b00, 0, 0, 2'b00, 0, 0, 0});
        vecs.push_back('{2'b00, 0, 0,             0, 0, 0,            1, 32'h600, 32'h77, 0, 32'h0, 2'b00, 0, 0, 2'b00, 0, 0, 0});
        vecs.push_back('{2'b00, 0, 0,             0, 0, 0,            1, 32'h503, 32'h77, 0, 32'h0, 2'b00, 0, 0, 2'b00, 0, 0, 0});
        vecs.push_back('{2'b00, 0, 0,             0, 0, 0,            0, 0, 0,  0, 32'h0,   2'b00, 0, 0, 2'b10, 0, 32'h77, 0});
        // Stall for 3 cycles, overflow on queued slot, original address kept
        vecs.push_back('{2'b01, 32'h700, 0,       0, 0, 0,            0, 0, 0,  0, 32'h0,   2'b00, 0, 0, 2'b00, 0, 0, 0});
        vecs.push_back('{2'b00, 0, 0,             1, 1, 32'hF00DF00D, 0, 0, 0,  0, 32'h0,   2'b00, 0, 0, 2'b00, 0, 0, 0});
        vecs.push_back('{2'b01, 32'h704, 0,       1, 1, 32'hF00DF00D, 0, 0, 0,  0, 32'h0,   2'b00, 0, 0, 2'b00, 0, 0, 0});
        vecs.push_back('{2'b00, 0, 0,             1, 1, 32'hF00DF00D, 0, 0, 0,  0, 32'h0,   2'b00, 0, 0, 2'b00, 0, 0, 1});
        vecs.push_back('{2'b00, 0, 0,             0, 1, 32'hF00DF00D, 0, 0, 0,  1, 32'h700, 2'b00, 0, 0, 2'b00, 0, 0, 1});
        vecs.push_back('{2'b00, 0, 0,             0, 0, 0,            0, 0, 0,  0, 32'h0,   2'b01, 32'hF00DF00D, 0, 2'b00, 0, 0, 1});

        idle_inputs();
        reset = 1'b1;
        repeat (2) @(posedge clock);
        #1;
        reset = 1'b0;
        #3;
        chk_all_zero("reset");
        tick();

        foreach (vecs[i]) begin
            ld_read_EN = vecs[i].rd;
            ld_addr    = {vecs[i].a1, vecs[i].a0};
            dc_stall   = vecs[i].stall;
            dc_is_hit  = vecs[i].hit;
            dc_data    = vecs[i].dd;
            dc_bc_en   = vecs[i].bce;
            dc_bc_addr = vecs[i].bca;
            dc_bc_data = vecs[i].bcd;
            #3;
            chk($sformatf("row%0d dc_read_EN", i), 64'(dc_read_EN), 64'(vecs[i].e_rd));
            chk($sformatf("row%0d dc_addr", i), 64'(dc_addr), 64'(vecs[i].e_addr));
            chk($sformatf("row%0d ld_is_hit", i), 64'(ld_is_hit), 64'(vecs[i].e_hit));
            chk($sformatf("row%0d ld_data", i), 64'(ld_data), {vecs[i].e_d1, vecs[i].e_d0});
            chk($sformatf("row%0d ld_broadcast_en", i), 64'(ld_broadcast_en), 64'(vecs[i].e_bc));
            chk($sformatf("row%0d ld_broadcast_data", i), 64'(ld_broadcast_data), {vecs[i].e_b1, vecs[i].e_b0});
            chk($sformatf("row%0d err_overflow", i), 64'(err_overflow), 64'(vecs[i].e_err));
            tick();
        end

        // Reset clears the sticky overflow flag
        idle_inputs();
        reset = 1'b1;
        tick();
        reset = 1'b0;
        #3;
        chk_all_zero("post_reset");
        tick();

        // Reset while FU0 is waiting on a miss discards it
        ld_read_EN = 2'b01;
        ld_addr    = {32'h0, 32'h800};
        tick();
        idle_inputs();
        #3;
        chk("midmiss grant dc_addr", 64'(dc_addr), 64'h800);
        tick();
        reset      = 1'b1;
        dc_bc_en   = 1'b1;
        dc_bc_addr = 32'h800;
        dc_bc_data = 32'h99999999;
        tick();
        reset = 1'b0;
        #3;
        chk_all_zero("midmiss reset");
        tick();
        idle_inputs();
        #3;
        chk_all_zero("midmiss after_fill");
        tick();

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire
